// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and address map for the AHB2APB bridge APB master.
// Slave n owns a 4 KiB window starting at APB_BASE + n*SLV_SPAN.
package apb_master_ctrl_pkg;

  localparam int PADDR_WIDTH    = 32;
  localparam int NUM_APB_SLAVES = 12;

  localparam logic [31:0] APB_BASE = 32'h4000_0000;
  localparam logic [31:0] SLV_SPAN = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic logic [31:0] start_paddr(input int i);
    return APB_BASE + (32'(i) << 12);
  endfunction

  function automatic logic [31:0] end_paddr(input int i);
    return start_paddr(i) + SLV_SPAN - 32'd1;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Lowest-index select from the decoder result and the matching
// slave response mux (pready/pslverr/prdata).
module apb_rsp_mux #(
  parameter int NSLV   = 12,
  parameter int DATA_W = 32
)(
  input  logic [NSLV-1:0]        psel_int,
  input  logic [NSLV-1:0]        pready_s,
  input  logic [NSLV-1:0]        pslverr_s,
  input  logic [NSLV*DATA_W-1:0] prdata_s,
  output logic [NSLV-1:0]        sel_oh,
  output logic                   hit,
  output logic                   pready,
  output logic                   pslverr,
  output logic [DATA_W-1:0]      prdata
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic [SW-1:0] sel;

  // descending scan so the lowest set bit wins
  always_comb begin
    sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (psel_int[i]) sel = SW'(i);
    end
  end

  assign sel_oh  = psel_int & (~psel_int + 1'b1);
  assign hit     = |psel_int;
  assign pready  = pready_s[sel];
  assign pslverr = pslverr_s[sel];
  assign prdata  = prdata_s[int'(sel)*DATA_W +: DATA_W];

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master FSM of the AHB2APB bridge: one request at a time,
// SETUP/ACCESS sequencing, timeout abort and single-cycle response.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int ADDR_W  = PADDR_WIDTH,
  parameter int DATA_W  = 32,
  parameter int NSLV    = NUM_APB_SLAVES,
  parameter int TIMEOUT = 255
)(
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [NSLV-1:0]        psel_int,
  output logic [ADDR_W-1:0]      paddr,
  output logic                   pwrite,
  output logic [DATA_W-1:0]      pwdata,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  input  logic [NSLV-1:0]        pready_s,
  input  logic [NSLV-1:0]        pslverr_s,
  input  logic [NSLV*DATA_W-1:0] prdata_s,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pen_d;
  logic                rsp_valid_d;
  logic                rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                accept;
  logic [NSLV-1:0]     sel_oh;
  logic                hit;
  logic                m_pready;
  logic                m_pslverr;
  logic [DATA_W-1:0]   m_prdata;

  apb_rsp_mux #(
    .NSLV   (NSLV),
    .DATA_W (DATA_W)
  ) u_mux (
    .psel_int  (psel_int),
    .pready_s  (pready_s),
    .pslverr_s (pslverr_s),
    .prdata_s  (prdata_s),
    .sel_oh    (sel_oh),
    .hit       (hit),
    .pready    (m_pready),
    .pslverr   (m_pslverr),
    .prdata    (m_prdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // select depends only on registered paddr and state
  assign psel = ((state_q == ST_SETUP && hit) ||
                 state_q == ST_ACCESS) ? sel_oh : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pen_d       = penable;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (hit) begin
          pen_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (m_pready) begin
          pen_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = m_pslverr;
          rsp_rdata_d = (!pwrite && !m_pslverr) ? m_prdata : '0;
          state_d     = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CLAST) begin
          pen_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_IDLE;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        pen_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      penable   <= pen_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (accept) begin
      paddr  <= req_addr;
      pwrite <= req_write;
      pwdata <= req_wdata;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed table, random transfers
// against a transfer-level model, and an async reset sequence.
module tb_apb_master_ctrl;
  import apb_master_ctrl_pkg::*;

  localparam int AW = PADDR_WIDTH;
  localparam int DW = 32;
  localparam int NS = NUM_APB_SLAVES;
  localparam int TO = 4;

  logic            hclk;
  logic            hreset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [NS-1:0]   psel_int;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [NS-1:0]   psel;
  logic            penable;
  logic [NS-1:0]   pready_s;
  logic [NS-1:0]   pslverr_s;
  logic [NS*DW-1:0] prdata_s;
  logic            rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  logic [NS-1:0]   ovl;
  int              total;
  int              bad;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  apb_master_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NSLV    (NS),
    .TIMEOUT (TO)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .psel_int  (psel_int),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .pready_s  (pready_s),
    .pslverr_s (pslverr_s),
    .prdata_s  (prdata_s),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int dec_idx(input logic [31:0] a);
    if (a < APB_BASE) return -1;
    if (a - APB_BASE >= SLV_SPAN * NS) return -1;
    return int'((a - APB_BASE) / SLV_SPAN);
  endfunction

  function automatic logic [NS-1:0] onehot(input int i);
    logic [NS-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // address decoder stand-in, plus optional overlapping higher hits
  always_comb psel_int = onehot(dec_idx(paddr)) | ovl;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic drive_slaves(input int idx, input logic rdy,
                              input vec_t v);
    for (int i = 0; i < NS; i++) begin
      pready_s[i]  = 1'($urandom);
      pslverr_s[i] = 1'($urandom);
      prdata_s[i*DW +: DW] = $urandom;
    end
    if (idx >= 0) begin
      pready_s[idx]  = rdy;
      pslverr_s[idx] = v.err;
      prdata_s[idx*DW +: DW] = v.rdata;
    end
  endtask

  task automatic noise_req();
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic do_xfer(input vec_t v);
    int idx, pen, r;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_sel;
    idx = dec_idx(v.addr);
    if (idx < 0) begin
      pen = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (v.waits >= TO) begin
      pen = TO; exp_err = 1'b1; exp_rd = '0;
    end else begin
      pen = v.waits + 1;
      exp_err = v.err;
      exp_rd = (!v.wr && !v.err) ? v.rdata : 32'h0;
    end
    r = 2 + pen;
    exp_sel = onehot(idx);
    @(negedge hclk);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    ovl = (idx >= 0) ?
      (NS'($urandom) & ~((NS'(2) << idx) - NS'(1))) : '0;
    drive_slaves(idx, 1'b0, v);
    @(posedge hclk); #1;
    req_valid = 1'b0;
    noise_req();
    for (int n = 1; n <= r; n++) begin
      chk("psel", 64'(psel),
          64'((idx >= 0 && n < r) ? exp_sel : '0));
      chk("penable", 64'(penable),
          64'(idx >= 0 && n >= 2 && n < r));
      chk("rsp_valid", 64'(rsp_valid), 64'(n == r));
      chk("req_ready", 64'(req_ready), 64'(n == r));
      chk("paddr", 64'(paddr), 64'(v.addr));
      chk("pwrite", 64'(pwrite), 64'(v.wr));
      chk("pwdata", 64'(pwdata), 64'(v.wdata));
      if (n == r) begin
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        break;
      end
      @(negedge hclk);
      drive_slaves(idx, (n >= 2 && n - 2 == v.waits), v);
      @(posedge hclk); #1;
    end
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad = 0;
    hreset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    ovl = '0;
    pready_s = '0;
    pslverr_s = '0;
    prdata_s = '0;
    #1;
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_pwrite", 64'(pwrite), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;

    tbl.push_back('{1'b0, start_paddr(3) + 32'd4, 32'h0, 0,
                    1'b0, 32'hCAFE_0003});
    tbl.push_back('{1'b1, start_paddr(0) + 32'd8, 32'h1234_5678, 3,
                    1'b0, 32'hDEAD_0000});
    tbl.push_back('{1'b0, 32'h5000_0000, 32'h0, 0,
                    1'b0, 32'h1111_1111});
    tbl.push_back('{1'b0, start_paddr(5), 32'h0, 50,
                    1'b0, 32'h5555_5555});
    tbl.push_back('{1'b0, start_paddr(7) + 32'h10, 32'h0, 0,
                    1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{1'b1, end_paddr(NS - 1), 32'hA5A5_5A5A, 1,
                    1'b0, 32'h0});
    tbl.push_back('{1'b0, start_paddr(0), 32'h0, TO - 1,
                    1'b0, 32'h0BAD_F00D});
    tbl.push_back('{1'b0, start_paddr(4), 32'h0, TO,
                    1'b0, 32'h4444_4444});
    tbl.push_back('{1'b1, start_paddr(7), 32'h7777_0000, 2,
                    1'b1, 32'h7777_7777});
    tbl.push_back('{1'b0, end_paddr(NS - 1) + 32'd1, 32'h0, 0,
                    1'b0, 32'h2222_2222});
    tbl.push_back('{1'b0, APB_BASE - 32'd4, 32'h0, 0,
                    1'b0, 32'h3333_3333});
    foreach (tbl[i]) do_xfer(tbl[i]);

    for (int k = 0; k < 150; k++) begin
      v.wr = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        v.addr = start_paddr($urandom_range(0, NS - 1)) +
                 32'($urandom_range(0, 1023) * 4);
      else if (1'($urandom))
        v.addr = 32'h5000_0000 + 32'($urandom_range(0, 4095));
      else
        v.addr = APB_BASE - 32'd4 - 32'($urandom_range(0, 4095));
      v.wdata = $urandom;
      v.waits = $urandom_range(0, TO + 2);
      v.err   = ($urandom_range(0, 3) == 0);
      v.rdata = $urandom;
      do_xfer(v);
    end

    // reset in the middle of an ACCESS phase
    v = '{1'b0, start_paddr(2), 32'h0, 50, 1'b0, 32'h2222_0002};
    @(negedge hclk);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr = v.addr;
    req_wdata = v.wdata;
    ovl = '0;
    drive_slaves(2, 1'b0, v);
    @(posedge hclk); #1;
    req_valid = 1'b0;
    @(posedge hclk); #1;
    chk("mid_penable", 64'(penable), 64'(1));
    chk("mid_psel", 64'(psel), 64'(onehot(2)));
    #2 hreset = 1'b1;
    #1;
    chk("arst_psel", 64'(psel), 64'(0));
    chk("arst_penable", 64'(penable), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(1));
    chk("arst_paddr", 64'(paddr), 64'(0));
    for (int n = 0; n < 2; n++) begin
      @(posedge hclk); #1;
      chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    hreset = 1'b0;
    do_xfer('{1'b0, start_paddr(9) + 32'h40, 32'h0, 0,
              1'b0, 32'h9999_0009});
    do_xfer('{1'b1, start_paddr(1), 32'hCCCC_0001, 1,
              1'b0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
